// File: rtl/mem_copy_dma.sv
// Byte-wise memory-to-memory copy engine for a 256 x 8b single-port data memory.
// Each byte takes one read cycle then one write cycle, ascending from the base addresses.
module mem_copy_dma (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] src_addr_i,
  input  logic [7:0] dst_addr_i,
  input  logic [7:0] len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] xfer_cnt_o,
  output logic       data_mem_rd_enb_o,
  output logic       data_mem_wr_enb_o,
  output logic [7:0] data_mem_addr_o,
  output logic [7:0] data_mem_wr_data_o,
  input  logic [7:0] data_mem_rd_data_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_src;
  logic [7:0] r_dst;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_buf;
  logic       r_busy;
  logic       r_done;
  logic       r_rd_enb;
  logic       r_wr_enb;
  logic [7:0] r_addr;

  logic [7:0] w_idx_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_wr_addr;
  logic [7:0] w_rd_addr_nxt;

  // 8-bit sums wrap modulo 256 naturally, giving address wrap for free.
  assign w_idx_nxt     = r_idx + 8'd1;
  assign w_cnt_nxt     = r_cnt + 8'd1;
  assign w_wr_addr     = r_dst + r_idx;
  assign w_rd_addr_nxt = r_src + w_idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_src    <= 8'd0;
      r_dst    <= 8'd0;
      r_len    <= 8'd0;
      r_idx    <= 8'd0;
      r_cnt    <= 8'd0;
      r_buf    <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_enb <= 1'b0;
      r_wr_enb <= 1'b0;
      r_addr   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_src <= src_addr_i;
            r_dst <= dst_addr_i;
            r_len <= len_i;
            r_idx <= 8'd0;
            r_cnt <= 8'd0;
            if (len_i != 8'd0) begin
              r_state  <= S_RD;
              r_busy   <= 1'b1;
              r_rd_enb <= 1'b1;
              r_addr   <= src_addr_i;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_buf    <= data_mem_rd_data_i;
          r_state  <= S_WR;
          r_rd_enb <= 1'b0;
          r_wr_enb <= 1'b1;
          r_addr   <= w_wr_addr;
        end
        S_WR: begin
          r_idx    <= w_idx_nxt;
          r_cnt    <= w_cnt_nxt;
          r_wr_enb <= 1'b0;
          if (w_cnt_nxt == r_len) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_addr  <= 8'd0;
          end else begin
            r_state  <= S_RD;
            r_rd_enb <= 1'b1;
            r_addr   <= w_rd_addr_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o             = r_busy;
  assign done_o             = r_done;
  assign xfer_cnt_o         = r_cnt;
  assign data_mem_rd_enb_o  = r_rd_enb;
  assign data_mem_wr_enb_o  = r_wr_enb;
  assign data_mem_addr_o    = r_addr;
  // Buffer stays latched between copies, so the bus is gated outside WR.
  assign data_mem_wr_data_o = r_wr_enb ? r_buf : 8'd0;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural 256-byte memory plus an ascending-copy reference model.
module tb_mem_copy_dma;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] src_addr_i, dst_addr_i, len_i;
  logic       busy_o, done_o;
  logic [7:0] xfer_cnt_o;
  logic       rd_en, wr_en;
  logic [7:0] maddr, wdata, rdata;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       pk_en = 1'b0;
  logic [7:0] pk_a = 8'd0, pk_d = 8'd0;

  int pass_cnt = 0;
  int total = 0;

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    int         exp_done;
    int         exp_cnt;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .xfer_cnt_o(xfer_cnt_o),
    .data_mem_rd_enb_o(rd_en), .data_mem_wr_enb_o(wr_en),
    .data_mem_addr_o(maddr), .data_mem_wr_data_o(wdata),
    .data_mem_rd_data_i(rdata)
  );

  assign rdata = rd_en ? mem[maddr] : 8'h00;

  always @(posedge clk) begin
    if (wr_en) mem[maddr] <= wdata;
    else if (pk_en) mem[pk_a] <= pk_d;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(negedge clk);
    pk_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Reference: plain ascending byte copy, later bytes see earlier writes.
  task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    for (int k = 0; k < int'(n); k++) ref_mem[d + 8'(k)] = ref_mem[s + 8'(k)];
  endtask

  function automatic int mem_diffs();
    int c = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                          input string tag, output int done_at, output int cnt);
    logic [7:0] exp_w [256];
    logic [7:0] ea;
    int errs = 0;
    int busy_cyc = 0;
    int k;
    ref_copy(s, d, n);
    for (int i = 0; i < int'(n); i++) exp_w[i] = ref_mem[d + 8'(i)];
    done_at = 0;
    @(negedge clk);
    start_i = 1'b1; src_addr_i = s; dst_addr_i = d; len_i = n;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c <= 2 * int'(n) + 3; c++) begin
      if (rd_en && wr_en) errs++;
      if (busy_o) busy_cyc++;
      if (c <= 2 * int'(n)) begin
        k = (c - 1) / 2;
        if (c % 2 == 1) begin
          ea = s + 8'(k);
          if (!(rd_en && !wr_en && maddr == ea && busy_o)) errs++;
        end else begin
          ea = d + 8'(k);
          if (!(wr_en && !rd_en && maddr == ea && wdata == exp_w[k] && busy_o)) errs++;
        end
      end else if (rd_en || wr_en || maddr != 8'd0 || wdata != 8'd0 || busy_o) begin
        errs++;
      end
      if (done_o) begin
        if (done_at == 0) done_at = c;
        else errs++;
      end
      @(posedge clk); #1;
    end
    cnt = int'(xfer_cnt_o);
    check({tag, " bus_protocol_errors"}, errs, 0);
    check({tag, " busy_cycles"}, busy_cyc, 2 * int'(n));
    check({tag, " memory_diffs"}, mem_diffs(), 0);
  endtask

  initial begin
    int da, cn;
    int dones [$];
    logic [7:0] rs, rd, rn;
    logic [7:0] a7;
    logic       r7;

    vecs[0] = '{8'h10, 8'h80, 8'd4, 9, 4};
    vecs[1] = '{8'h00, 8'h40, 8'd0, 1, 0};
    vecs[2] = '{8'hFE, 8'h01, 8'd3, 7, 3};
    vecs[3] = '{8'h20, 8'h21, 8'd3, 7, 3};
    vecs[4] = '{8'hF0, 8'hF8, 8'd16, 33, 16};

    start_i = 1'b0; src_addr_i = 8'h00; dst_addr_i = 8'h00; len_i = 8'h00;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    check("reset_outputs", {busy_o, done_o, xfer_cnt_o, rd_en, wr_en, maddr, wdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    poke(8'h20, 8'h55);

    for (int v = 0; v < 5; v++) begin
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, $sformatf("vec%0d", v), da, cn);
      check($sformatf("vec%0d done_cycle", v), da, vecs[v].exp_done);
      check($sformatf("vec%0d xfer_cnt", v), cn, vecs[v].exp_cnt);
      if (v == 0)
        check("vec0 dst_bytes", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'hA1B2C3D4);
      if (v == 3)
        check("vec3 overlap_bytes", {mem[8'h21], mem[8'h22], mem[8'h23]}, 24'h555555);
    end

    // Start held high with changing parameters: second request runs only after DONE.
    @(negedge clk);
    start_i = 1'b1; src_addr_i = 8'h40; dst_addr_i = 8'hA0; len_i = 8'd2;
    @(posedge clk); #1;
    src_addr_i = 8'h50; dst_addr_i = 8'hB0; len_i = 8'd3;
    ref_copy(8'h40, 8'hA0, 8'd2);
    ref_copy(8'h50, 8'hB0, 8'd3);
    a7 = 8'h00; r7 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (done_o) dones.push_back(c);
      if (c == 6) check("held_start idle_busy", {busy_o, rd_en, wr_en}, 0);
      if (c == 7) begin
        a7 = maddr; r7 = rd_en;
        start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("held_start second_rd", {r7, a7}, {1'b1, 8'h50});
    check("held_start done_count", dones.size(), 2);
    if (dones.size() == 2) begin
      check("held_start done_first", dones[0], 5);
      check("held_start done_second", dones[1], 13);
    end
    check("held_start memory_diffs", mem_diffs(), 0);

    // Abort during the write of byte 1 of a 4-byte copy.
    ref_mem[8'h90] = ref_mem[8'h30];
    @(negedge clk);
    start_i = 1'b1; src_addr_i = 8'h30; dst_addr_i = 8'h90; len_i = 8'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_outputs", {busy_o, done_o, xfer_cnt_o, rd_en, wr_en, maddr, wdata}, 0);
    da = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_o || wr_en) da++;
    end
    check("abort_no_activity", da, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", {busy_o, done_o}, 0);
    check("abort_memory_diffs", mem_diffs(), 0);
    run_copy(8'h30, 8'h90, 8'd4, "post_abort", da, cn);
    check("post_abort done_cycle", da, 9);
    check("post_abort xfer_cnt", cn, 4);

    for (int t = 0; t < 12; t++) begin
      rs = 8'($urandom); rd = 8'($urandom); rn = 8'($urandom_range(0, 24));
      run_copy(rs, rd, rn, $sformatf("rand%0d", t), da, cn);
      check($sformatf("rand%0d done_cycle", t), da, 2 * int'(rn) + 1);
      check($sformatf("rand%0d xfer_cnt", t), cn, int'(rn));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 The block SHALL have no parameters; all address, data and length widths SHALL be fixed at 8 bits, matching the 256 x 8b data memory.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; SHALL force the reset state immediately when low, independent of clk.
REQ-004 start_i  input  1  copy request; sampled only in IDLE.
REQ-005 src_addr_i  input  8  source base address.
REQ-006 dst_addr_i  input  8  destination base address.
REQ-007 len_i  input  8  byte count, 0..255.
REQ-008 busy_o  output  1  high while a copy is in progress (RD or WR state).
REQ-009 done_o  output  1  single-cycle completion pulse.
REQ-010 xfer_cnt_o  output  8  number of bytes already written in the current or last copy.
REQ-011 data_mem_rd_enb_o  output  1  memory read enable.
REQ-012 data_mem_wr_enb_o  output  1  memory write enable.
REQ-013 data_mem_addr_o  output  8  memory address.
REQ-014 data_mem_wr_data_o  output  8  memory write data.
REQ-015 data_mem_rd_data_i  input  8  memory read data; combinational from address and read enable, valid in the same cycle.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RD, WR and DONE.
REQ-017 IDLE: when start_i=1 at a rising edge, the block SHALL latch src_addr_i, dst_addr_i and len_i, clear the index and xfer_cnt_o to 0, and go to RD if len_i!=0 or to DONE if len_i==0.
REQ-018 IDLE with start_i=0 SHALL remain in IDLE.
REQ-019 RD SHALL drive data_mem_rd_enb_o=1, data_mem_wr_enb_o=0 and data_mem_addr_o=src+idx (mod 256).
REQ-020 RD SHALL capture data_mem_rd_data_i into an internal byte buffer at the rising edge and then go to WR.
REQ-021 WR SHALL drive data_mem_wr_enb_o=1, data_mem_rd_enb_o=0, data_mem_addr_o=dst+idx (mod 256) and data_mem_wr_data_o=buffer.
REQ-022 At the rising edge ending WR, idx and xfer_cnt_o SHALL increment by 1; the block SHALL go to DONE if the new count equals the latched length, else to RD.
REQ-023 DONE SHALL assert done_o=1 for exactly one cycle and then return unconditionally to IDLE.
REQ-024 Latency: for length N>0, with start sampled at edge E0, byte k SHALL be read in cycle 2k+1 and written in cycle 2k+2, and done_o SHALL be high in cycle 2N+1.
REQ-025 Latency for length 0: done_o SHALL be high in cycle 1 with no memory enable asserted.
REQ-026 busy_o SHALL be 1 in RD and WR and 0 in IDLE and DONE.
REQ-027 start_i SHALL be ignored in RD, WR and DONE; the latched parameters SHALL NOT change mid-copy.
REQ-028 Source and destination addresses SHALL wrap modulo 256 (e.g. 8'hFF+1=8'h00).
REQ-029 The copy SHALL always run in ascending order; overlapping regions with dst>src SHALL propagate already-written bytes, and this behaviour is specified, not an error.
REQ-030 data_mem_rd_enb_o and data_mem_wr_enb_o SHALL never be high in the same cycle.
REQ-031 In IDLE and DONE, both enables, data_mem_addr_o and data_mem_wr_data_o SHALL be 0.
REQ-032 xfer_cnt_o SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-033 With rst=0, the state SHALL be IDLE and busy_o, done_o, xfer_cnt_o, both enables, data_mem_addr_o, data_mem_wr_data_o, the buffer, idx and the latched parameters SHALL all be 0.
REQ-034 Reset asserted mid-copy SHALL abort immediately with no further memory write and no done_o pulse; after rst rises, the block SHALL be in IDLE awaiting start_i.

Verification
REQ-035 Memory preloaded with mem[0x10..0x13]=A1,B2,C3,D4; start with src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]=A1,B2,C3,D4, done_o high in cycle 9 only, xfer_cnt_o=4, busy_o high in cycles 1-8.
REQ-036 len=0, src=0x00, dst=0x40 -> done_o high in cycle 1, no enable ever high, memory unchanged.
REQ-037 src=0xFE, dst=0x01, len=3 -> reads hit addresses FE, FF, 00 and writes hit 01, 02, 03 in order, demonstrating wrap.
REQ-038 start_i held high with new parameters for the whole copy -> only the first request executes; a second copy starts only if start_i is still high in IDLE after the done_o cycle.
REQ-039 rst pulled low in cycle 4 of a len=4 copy -> outputs 0 immediately, destination holds only byte 0, no done_o pulse, and a new copy after release completes normally.
REQ-040 Overlap with src=0x20, dst=0x21, len=3 and mem[0x20]=55 -> mem[0x21..0x23]=55,55,55.
